qlearn_step_controller: RTL and testbench
=========================================

Name: qlearn_step_controller

Overview:
- Sequences one agent step of the Q-learning pipeline: fetches the four Q-values of the current state from the Q-table RAM, drives the ActionSelector (packed q_values, epsilon, active-low start), forwards the chosen action to the environment and waits for its handshake.
- Owns the per-episode epsilon decay schedule and the step/episode counters.
- Sits between the Q-table memory, the ActionSelector and the environment model.

Parameters:
- QW, 16, Q-value and epsilon width (Q8.8 fixed point)
- SW, 4, state index width
- EPS_INIT, 16'h0100, epsilon after reset (1.0)
- EPS_MIN, 16'h0010, epsilon floor
- EPS_SHIFT, 4, decay: eps -= eps >> EPS_SHIFT per episode
- MAX_STEPS, 64, step limit per episode
- SEL_LAT, 1, cycles from sel_start low until sel_action is valid
- START_STATE, 0, state loaded at each episode start

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  enable episode loop; sampled only in IDLE and at episode end
- qt_rd_en  out  1  Q-table read strobe
- qt_rd_addr  out  SW+2  {state, action_idx}
- qt_rd_data  in  QW  read data, valid 1 cycle after qt_rd_en
- sel_start  out  1  ActionSelector start, active-low
- sel_q_values  out  4*QW  packed Q-values; action k at bits [QW*k +: QW]
- sel_epsilon  out  QW  current epsilon
- sel_action  in  4  one-hot action from selector
- env_req  out  1  step request to environment
- env_action  out  2  encoded action index
- env_ack  in  1  environment step complete
- env_next_state  in  SW  next state, valid with env_ack
- env_done  in  1  terminal flag, valid with env_ack
- state  out  SW  current state
- step_cnt  out  8  steps in current episode
- episode_cnt  out  16  completed episodes, wraps at 16'hFFFF -> 0
- busy  out  1  high whenever FSM is not IDLE
- sel_err  out  1  sticky: sel_action not one-hot

Behaviour:
- Reset values: FSM=IDLE, qt_rd_en=0, qt_rd_addr=0, sel_start=1, sel_q_values=0, sel_epsilon=EPS_INIT, env_req=0, env_action=0, state=START_STATE, step_cnt=0, episode_cnt=0, busy=0, sel_err=0. A reset asserted in any state aborts the operation and returns to these values the next cycle.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - 5 cycles; qt_rd_en high on cycles 0..3 with addr {state,k}, k=0..3.
  - Data for k captured one cycle later into sel_q_values slot k.
  - Then go to SELECT.
- SELECT:
  - sel_start low for exactly 1 cycle, then high.
  - Wait SEL_LAT cycles, then sample sel_action.
  - Encode the lowest set bit into env_action.
  - Zero or multi-hot input: use lowest set bit (0 if none) and set sel_err (cleared only by rst).
  - Go to ENV.
- ENV:
  - env_req asserted the cycle after SELECT and held, with env_action stable, until the cycle env_ack=1 is sampled.
  - env_req drops the following cycle.
  - env_ack while env_req=0 is ignored.
  - No timeout.
- ADVANCE (1 cycle):
  - state <= env_next_state; step_cnt increments.
  - If env_done=1 or the new step_cnt==MAX_STEPS, go to EP_END; else go to FETCH.
- EP_END (1 cycle):
  - eps_next = eps - (eps >> EPS_SHIFT), unsigned. If eps_next < EPS_MIN, eps_next = EPS_MIN.
  - episode_cnt++; step_cnt <= 0; state <= START_STATE.
  - Then go to FETCH if run=1, else IDLE.
  - run falling mid-episode has no effect until EP_END.
- Step latency with env_ack returned 1 cycle after env_req (SEL_LAT=1): FETCH 5 + SELECT 2 + ENV 2 + ADVANCE 1 = 10 cycles.
- sel_epsilon changes only in EP_END and is stable throughout each step.

Test Plan:
- Reset, run=1, RAM holds state 0 = {3,2,1,12}, selector returns 4'b1000: sel_q_values=64'h000C_0001_0002_0003; env_action=3; env_req high until ack.
- env_ack delayed 5 cycles, then env_next_state=5, env_done=0: env_req high exactly 5 cycles, stable env_action; state=5; step_cnt=1; next FETCH addresses {5,0}..{5,3}.
- Three episodes each terminated by env_done: epsilon sequence 0x0100 -> 0x00F0 -> 0x00E1 -> 0x00D3; episode_cnt=3; state returns to 0.
- env_done never asserted: EP_END after exactly 64 steps; step_cnt clears; epsilon decays once. Run many episodes: epsilon saturates at 0x0010, never below.
- sel_action=4'b0000, then a later step with 4'b0110: first case gives env_action=0, second gives 1; sel_err set and stays set until rst.
- rst asserted mid-ENV with env_req high: next cycle env_req=0, busy=0, epsilon=0x0100, counters 0. Dropping run mid-episode: episode completes, then IDLE.

Source files
------------

// File: rtl/qlearn_step_controller_if.sv
// Bus bundle between the step controller and the Q-table RAM, ActionSelector and environment.
interface qlearn_step_controller_if #(
  parameter int QW = 16,
  parameter int SW = 4
);
  logic            qt_rd_en;
  logic [SW+1:0]   qt_rd_addr;
  logic [QW-1:0]   qt_rd_data;
  logic            sel_start;
  logic [4*QW-1:0] sel_q_values;
  logic [QW-1:0]   sel_epsilon;
  logic [3:0]      sel_action;
  logic            env_req;
  logic [1:0]      env_action;
  logic            env_ack;
  logic [SW-1:0]   env_next_state;
  logic            env_done;

  modport master (
    output qt_rd_en, qt_rd_addr, sel_start, sel_q_values, sel_epsilon, env_req, env_action,
    input  qt_rd_data, sel_action, env_ack, env_next_state, env_done
  );

  modport slave (
    input  qt_rd_en, qt_rd_addr, sel_start, sel_q_values, sel_epsilon, env_req, env_action,
    output qt_rd_data, sel_action, env_ack, env_next_state, env_done
  );
endinterface

// File: rtl/qlearn_step_controller.sv
// Sequences one Q-learning agent step (Q fetch, action select, environment handshake)
// and owns the per-episode epsilon decay plus step/episode counters.
module qlearn_step_controller #(
  parameter int              QW          = 16,
  parameter int              SW          = 4,
  parameter logic [QW-1:0]   EPS_INIT    = 16'h0100,
  parameter logic [QW-1:0]   EPS_MIN     = 16'h0010,
  parameter int              EPS_SHIFT   = 4,
  parameter int              MAX_STEPS   = 64,
  parameter int              SEL_LAT     = 1,
  parameter logic [SW-1:0]   START_STATE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  qlearn_step_controller_if.master bus,
  output logic [SW-1:0]            state,
  output logic [7:0]               step_cnt,
  output logic [15:0]              episode_cnt,
  output logic                     busy,
  output logic                     sel_err
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_SELECT  = 3'd2;
  localparam logic [2:0] S_ENV     = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_EP_END  = 3'd5;

  logic [2:0]      fsm;
  logic [3:0]      cnt;
  logic [4*QW-1:0] q_values;
  logic [QW-1:0]   eps;
  logic [1:0]      action;
  logic [SW-1:0]   next_state_q;
  logic            done_q;
  logic [1:0]      act_enc;
  logic            act_onehot;
  logic [QW-1:0]   eps_dec;
  logic [QW-1:0]   eps_next;
  logic [7:0]      step_inc;

  // Lowest set bit wins, so multi-hot and all-zero selector outputs still yield an action.
  always_comb begin
    act_enc = 2'd0;
    if (bus.sel_action[0])      act_enc = 2'd0;
    else if (bus.sel_action[1]) act_enc = 2'd1;
    else if (bus.sel_action[2]) act_enc = 2'd2;
    else if (bus.sel_action[3]) act_enc = 2'd3;
  end

  assign act_onehot = $onehot(bus.sel_action);
  assign eps_dec    = eps - (eps >> EPS_SHIFT);
  assign eps_next   = (eps_dec < EPS_MIN) ? EPS_MIN : eps_dec;
  assign step_inc   = step_cnt + 8'd1;

  assign bus.qt_rd_en     = (fsm == S_FETCH) && (cnt < 4'd4);
  assign bus.qt_rd_addr   = bus.qt_rd_en ? {state, cnt[1:0]} : '0;
  assign bus.sel_start    = !((fsm == S_SELECT) && (cnt == 4'd0));
  assign bus.sel_q_values = q_values;
  assign bus.sel_epsilon  = eps;
  assign bus.env_req      = (fsm == S_ENV);
  assign bus.env_action   = action;
  assign busy             = (fsm != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= S_IDLE;
      cnt          <= '0;
      q_values     <= '0;
      eps          <= EPS_INIT;
      action       <= '0;
      state        <= START_STATE;
      step_cnt     <= '0;
      episode_cnt  <= '0;
      sel_err      <= 1'b0;
      next_state_q <= '0;
      done_q       <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (run) begin
            fsm <= S_FETCH;
            cnt <= '0;
          end
        end
        S_FETCH: begin
          // RAM data lags the strobe by one cycle, so slot k lands while cnt == k+1.
          for (int k = 0; k < 4; k++) begin
            if (cnt == 4'(k + 1)) q_values[QW*k +: QW] <= bus.qt_rd_data;
          end
          if (cnt == 4'd4) begin
            fsm <= S_SELECT;
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SELECT: begin
          if (cnt == 4'(SEL_LAT)) begin
            action <= act_enc;
            if (!act_onehot) sel_err <= 1'b1;
            fsm <= S_ENV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ENV: begin
          if (bus.env_ack) begin
            next_state_q <= bus.env_next_state;
            done_q       <= bus.env_done;
            fsm          <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          state    <= next_state_q;
          step_cnt <= step_inc;
          cnt      <= '0;
          fsm      <= (done_q || step_inc == 8'(MAX_STEPS)) ? S_EP_END : S_FETCH;
        end
        S_EP_END: begin
          eps         <= eps_next;
          episode_cnt <= episode_cnt + 16'd1;
          step_cnt    <= '0;
          state       <= START_STATE;
          cnt         <= '0;
          fsm         <= run ? S_FETCH : S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qlearn_step_controller.sv
// Randomized bench for qlearn_step_controller against a transaction-level model of the agent loop.
module tb_qlearn_step_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  state;
  logic [7:0]  step_cnt;
  logic [15:0] episode_cnt;
  logic        busy;
  logic        sel_err;

  qlearn_step_controller_if #(.QW(16), .SW(4)) bus ();

  qlearn_step_controller dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .state(state), .step_cnt(step_cnt), .episode_cnt(episode_cnt),
    .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [15:0] mem [64];
  logic [15:0] eps_tbl [4];

  // model of the agent loop
  logic [3:0]  m_state;
  int          m_step, m_ep, m_eps;
  logic        m_err;

  // current step plan
  logic [3:0]  plan_sel, plan_ns;
  int          plan_len;
  logic        plan_done;
  logic [63:0] exp_q;
  logic [1:0]  exp_act;
  logic        exp_err;

  // monitor bookkeeping
  int   cyc = 0, nrd = 0, reqn = 0, post = 0, prev_cyc = 0, exp_lat = 0;
  logic prev_start = 1'b1;
  logic exp_busy = 1'b1;
  bit   have_prev = 0, idle_seen = 0, long_env = 0;

  // shared with the RAM/selector driver
  logic       rd_pend = 1'b0, sel_pend = 1'b0;
  logic [5:0] rd_addr = '0;

  function automatic int low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Registered RAM and a selector that only shows the real answer on the valid cycle.
  initial forever begin
    @(posedge clk);
    #1;
    bus.qt_rd_data = rd_pend ? mem[rd_addr] : 16'($urandom);
    bus.sel_action = sel_pend ? plan_sel : 4'($urandom);
  end

  task automatic step_start();
    logic [3:0] oh;
    chk("state", 64'(state), 64'(m_state));
    chk("step_cnt", 64'(step_cnt), 64'(m_step));
    chk("episode_cnt", 64'(episode_cnt), 64'(m_ep));
    chk("epsilon", 64'(bus.sel_epsilon), 64'(m_eps));
    chk("busy_step", 64'(busy), 64'(1));
    if (m_step == 0 && m_ep <= 3) chk("eps_sequence", 64'(bus.sel_epsilon), 64'(eps_tbl[m_ep]));
    if (have_prev) chk("step_latency", 64'(cyc - prev_cyc), 64'(exp_lat));
    have_prev = 1;
    prev_cyc  = cyc;

    plan_len = $urandom_range(1, 4);
    plan_ns  = 4'($urandom);
    oh       = 4'b0001 << $urandom_range(0, 3);
    plan_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : oh;
    if (m_ep < 3)       plan_done = ($urandom_range(0, 2) == 0);
    else if (m_ep == 3) plan_done = 1'b0;
    else                plan_done = ($urandom_range(0, 1) == 0);
    if (m_ep == 0 && m_step == 0) begin
      plan_sel = 4'b1000; plan_len = 5; plan_ns = 4'd5; plan_done = 1'b0;
    end else if (m_ep == 0 && m_step == 1) begin
      plan_sel = 4'b0000; plan_done = 1'b0;
    end else if (m_ep == 0 && m_step == 2) begin
      plan_sel = 4'b0110; plan_done = 1'b1;
    end
    if (long_env) plan_len = 8;

    for (int k = 0; k < 4; k++) exp_q[16*k +: 16] = mem[{m_state, 2'(k)}];
    exp_act = 2'(low_idx(plan_sel));
    exp_err = m_err | ($countones(plan_sel) != 1);
    if (m_ep >= 60) run = 1'b0;
  endtask

  task automatic model_update();
    bit ended;
    m_err  = exp_err;
    m_step = m_step + 1;
    m_state = plan_ns;
    ended = plan_done || (m_step == 64);
    if (ended) begin
      m_eps = m_eps - m_eps / 16;
      if (m_eps < 16) m_eps = 16;
      m_ep    = m_ep + 1;
      m_step  = 0;
      m_state = 4'd0;
    end
    exp_lat  = 8 + plan_len + (ended ? 1 : 0);
    exp_busy = ended ? run : 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!prev_start) chk("sel_start_width", 64'(bus.sel_start), 64'(1));
    if (bus.qt_rd_en) begin
      if (nrd == 0) step_start();
      chk("rd_addr", 64'(bus.qt_rd_addr), 64'({m_state, 2'(nrd)}));
      nrd++;
    end
    rd_pend  = bus.qt_rd_en;
    rd_addr  = bus.qt_rd_addr;
    sel_pend = !bus.sel_start;
    if (!bus.sel_start) begin
      chk("n_reads", 64'(nrd), 64'(4));
      chk("q_values", bus.sel_q_values, exp_q);
      chk("eps_select", 64'(bus.sel_epsilon), 64'(m_eps));
      if (m_ep == 0 && m_step == 0) chk("first_q_values", bus.sel_q_values, 64'h000C_0001_0002_0003);
      nrd = 0;
    end
    prev_start = bus.sel_start;

    if (post == 2) begin
      chk("busy_after_step", 64'(busy), 64'(exp_busy));
      if (!exp_busy) idle_seen = 1;
      post = 0;
    end else if (post == 1) begin
      post = 2;
    end

    if (bus.env_req) begin
      reqn++;
      if (reqn == 1) chk("sel_err", 64'(sel_err), 64'(exp_err));
      if (m_ep == 0 && m_step == 0 && reqn == 1) chk("first_action", 64'(bus.env_action), 64'(3));
      chk("env_action", 64'(bus.env_action), 64'(exp_act));
      if (reqn == plan_len) begin
        bus.env_ack = 1'b1; bus.env_next_state = plan_ns; bus.env_done = plan_done;
      end else begin
        bus.env_ack = 1'b0; bus.env_next_state = 4'($urandom); bus.env_done = 1'($urandom);
      end
    end else begin
      if (reqn > 0) begin
        chk("req_len", 64'(reqn), 64'(plan_len));
        model_update();
        post = 1;
        reqn = 0;
      end
      // stray acks with no request outstanding must be ignored
      bus.env_ack        = ($urandom_range(0, 3) == 0);
      bus.env_next_state = 4'($urandom);
      bus.env_done       = 1'($urandom);
    end
  endtask

  initial begin
    int guard;
    eps_tbl[0] = 16'h0100; eps_tbl[1] = 16'h00F0; eps_tbl[2] = 16'h00E1; eps_tbl[3] = 16'h00D3;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'd3; mem[1] = 16'd2; mem[2] = 16'd1; mem[3] = 16'd12;
    bus.qt_rd_data = '0; bus.sel_action = '0;
    bus.env_ack = 1'b0; bus.env_next_state = '0; bus.env_done = 1'b0;
    m_state = '0; m_step = 0; m_ep = 0; m_eps = 16'h0100; m_err = 1'b0;
    plan_sel = '0; plan_ns = '0; plan_len = 1; plan_done = 1'b0;
    exp_q = '0; exp_act = '0; exp_err = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 64'(bus.qt_rd_en), 64'(0));
    chk("rst_rd_addr", 64'(bus.qt_rd_addr), 64'(0));
    chk("rst_sel_start", 64'(bus.sel_start), 64'(1));
    chk("rst_q_values", bus.sel_q_values, 64'(0));
    chk("rst_epsilon", 64'(bus.sel_epsilon), 64'h0100);
    chk("rst_env_req", 64'(bus.env_req), 64'(0));
    chk("rst_env_action", 64'(bus.env_action), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_step_cnt", 64'(step_cnt), 64'(0));
    chk("rst_episode_cnt", 64'(episode_cnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sel_err", 64'(sel_err), 64'(0));
    rst = 1'b0;
    run = 1'b1;

    guard = 0;
    while (!idle_seen && guard < 40000) begin
      tick();
      guard++;
    end
    chk("episode_loop_done", 64'(idle_seen), 64'(1));

    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_rd_en", 64'(bus.qt_rd_en), 64'(0));
    end
    chk("sel_err_sticky", 64'(sel_err), 64'(m_err));
    chk("eps_floor", 64'(bus.sel_epsilon), 64'h0010);
    chk("episodes_before_rst", 64'(episode_cnt), 64'(m_ep));

    have_prev = 0;
    long_env  = 1;
    run       = 1'b1;
    guard     = 0;
    while (reqn < 3 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reached_env", 64'(reqn >= 3), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_env_req", 64'(bus.env_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_epsilon", 64'(bus.sel_epsilon), 64'h0100);
    chk("mid_rst_step_cnt", 64'(step_cnt), 64'(0));
    chk("mid_rst_episode_cnt", 64'(episode_cnt), 64'(0));
    chk("mid_rst_state", 64'(state), 64'(0));
    chk("mid_rst_sel_err", 64'(sel_err), 64'(0));
    chk("mid_rst_sel_start", 64'(bus.sel_start), 64'(1));
    rst = 1'b0;
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
